// File: rtl/n_adder_pkg.sv
// n_adder shared types, defaults and reference helper.
// Optional overflow flag: N_ADDER_OVF_EN.
package n_adder_pkg;

  localparam int N_ADDER_DEFAULT_W = 8;
  localparam int N_ADDER_MAX_W     = 64;

  // Reference {carry, sum} of a w-bit add; operands must fit in w bits.
  function automatic logic [64:0] expected_sum(
    input logic [63:0] a,
    input logic [63:0] b,
    input logic        c_in,
    input int unsigned w
  );
    logic [64:0] full;
    logic [64:0] mask;
    full = {1'b0, a} + {1'b0, b} + {64'd0, c_in};
    mask = (65'd1 << (w + 1)) - 65'd1;
    return full & mask;
  endfunction

endpackage

// File: rtl/n_adder_if.sv
// n_adder operand/result bundle with master/slave views.
// ovf exists only with N_ADDER_OVF_EN.
interface n_adder_if #(
  parameter int N = 8
);

  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         c_in;
  logic [N-1:0] S;
  logic         c_out;
`ifdef N_ADDER_OVF_EN
  logic         ovf;
`endif

`ifdef N_ADDER_OVF_EN
  modport master (
    output A, B, c_in,
    input  S, c_out, ovf
  );

  modport slave (
    input  A, B, c_in,
    output S, c_out, ovf
  );
`else
  modport master (
    output A, B, c_in,
    input  S, c_out
  );

  modport slave (
    input  A, B, c_in,
    output S, c_out
  );
`endif

endinterface

// File: rtl/n_adder_full_adder.sv
// One-bit full adder cell for the n_adder ripple chain.
// Optional overflow flag: N_ADDER_OVF_EN (unused here).
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  // Propagate term shared by sum and carry.
  always_comb begin
    p  = a ^ b;
    s  = p ^ ci;
    co = (a & b) | (ci & p);
  end

endmodule

// File: rtl/n_adder.sv
// Registered N-bit ripple-carry adder, 1-cycle latency.
// Optional signed overflow output: N_ADDER_OVF_EN.
module n_adder
  import n_adder_pkg::*;
#(
  parameter int N = N_ADDER_DEFAULT_W
) (
  input logic     clk,
  input logic     rstn,
  n_adder_if.slave bus
);

  logic [N:0]   c;
  logic [N-1:0] s_next;
  logic [N-1:0] s_q;
  logic         c_out_q;

  assign c[0] = bus.c_in;

  for (genvar i = 0; i < N; i++) begin : g_fa
    full_adder u_fa (
      .a  (bus.A[i]),
      .b  (bus.B[i]),
      .ci (c[i]),
      .s  (s_next[i]),
      .co (c[i+1])
    );
  end

  // Sum and carry registers; reset wins over the sum in flight.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s_q     <= '0;
      c_out_q <= 1'b0;
    end else begin
      s_q     <= s_next;
      c_out_q <= c[N];
    end
  end

  assign bus.S     = s_q;
  assign bus.c_out = c_out_q;

`ifdef N_ADDER_OVF_EN
  logic ovf_q;

  // Signed overflow: carry into and out of the sign bit differ.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= c[N] ^ c[N-1];
    end
  end

  assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_n_adder.sv
// Directed and random checks of n_adder at N = 8, 1 and 64.
// Overflow checks are active with N_ADDER_OVF_EN.
module tb_n_adder;
  import n_adder_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  n_adder_if #(.N(8))  if8 ();
  n_adder_if #(.N(1))  if1 ();
  n_adder_if #(.N(64)) if64 ();

  n_adder #(.N(8))  u8  (.clk(clk), .rstn(rstn), .bus(if8.slave));
  n_adder #(.N(1))  u1  (.clk(clk), .rstn(rstn), .bus(if1.slave));
  n_adder #(.N(64)) u64 (.clk(clk), .rstn(rstn), .bus(if64.slave));

  task automatic chk(input string tag, input logic [64:0] obs,
                     input logic [64:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b,
                        input logic ci);
    if8.A    = a;
    if8.B    = b;
    if8.c_in = ci;
  endtask

  function automatic logic ovf_rule(input logic sa, input logic sb,
                                    input logic ss);
    return (sa == sb) && (ss != sa);
  endfunction

  logic [7:0]  a8, b8;
  logic [0:0]  a1, b1;
  logic [63:0] a64, b64;
  logic        c8, c1, c64;
  logic [64:0] e8, e1, e64;

  initial begin
    rstn = 1'b0;
    drive8(8'd5, 8'd10, 1'b0);
    if1.A = 1'b1; if1.B = 1'b1; if1.c_in = 1'b1;
    if64.A = '1; if64.B = '1; if64.c_in = 1'b1;
    tick();
    tick();
    chk("rst_8", {if8.c_out, if8.S}, 65'd0);
    chk("rst_1", {if1.c_out, if1.S}, 65'd0);
    chk("rst_64", {if64.c_out, if64.S}, 65'd0);
`ifdef N_ADDER_OVF_EN
    chk("rst_ovf8", if8.ovf, 65'd0);
    chk("rst_ovf64", if64.ovf, 65'd0);
`endif

    rstn = 1'b1;
    tick();
    chk("rel_5p10", {if8.c_out, if8.S}, 65'h00F);
`ifdef N_ADDER_OVF_EN
    chk("rel_5p10_ovf", if8.ovf, 65'd0);
`endif

    drive8(8'd30, 8'hF6, 1'b0);
    tick();
    chk("30m10", {if8.c_out, if8.S}, 65'h114);
`ifdef N_ADDER_OVF_EN
    chk("30m10_ovf", if8.ovf, 65'd0);
`endif

    drive8(8'd5, 8'hF6, 1'b1);
    tick();
    chk("5m10c1", {if8.c_out, if8.S}, 65'h0FC);
`ifdef N_ADDER_OVF_EN
    chk("5m10c1_ovf", if8.ovf, 65'd0);
`endif

    drive8(8'd127, 8'd1, 1'b0);
    tick();
    chk("maxp1", {if8.c_out, if8.S}, 65'h080);
`ifdef N_ADDER_OVF_EN
    chk("maxp1_ovf", if8.ovf, 65'd1);
`endif

    drive8(8'h80, 8'h80, 1'b0);
    tick();
    chk("min2", {if8.c_out, if8.S}, 65'h100);
`ifdef N_ADDER_OVF_EN
    chk("min2_ovf", if8.ovf, 65'd1);
`endif

    drive8(8'hFF, 8'h00, 1'b1);
    if1.A = 1'b1; if1.B = 1'b0; if1.c_in = 1'b1;
    if64.A = '1; if64.B = '0; if64.c_in = 1'b1;
    tick();
    chk("ones_c1_8", {if8.c_out, if8.S}, 65'h100);
    chk("ones_c1_1", {if1.c_out, if1.S}, 65'h2);
    chk("ones_c1_64", {if64.c_out, if64.S}, {1'b1, 64'd0});
`ifdef N_ADDER_OVF_EN
    chk("ones_c1_ovf8", if8.ovf, 65'd0);
    chk("ones_c1_ovf1", if1.ovf, 65'd0);
    chk("ones_c1_ovf64", if64.ovf, 65'd0);
`endif

    // 64-bit max positive + 1 and N=1 overflow (-1 + -1 + 1 = -1 ok, 0+0+1 = -1 ovf)
    if1.A = 1'b0; if1.B = 1'b0; if1.c_in = 1'b1;
    if64.A = 64'h7FFF_FFFF_FFFF_FFFF; if64.B = 64'd1; if64.c_in = 1'b0;
    tick();
    chk("n1_001", {if1.c_out, if1.S}, 65'h1);
    chk("n64_maxp1", {if64.c_out, if64.S}, {1'b0, 64'h8000_0000_0000_0000});
`ifdef N_ADDER_OVF_EN
    chk("n1_001_ovf", if1.ovf, 65'd1);
    chk("n64_maxp1_ovf", if64.ovf, 65'd1);
`endif

    // Reset mid-stream discards the sum in flight.
    drive8(8'd100, 8'd50, 1'b0);
    rstn = 1'b0;
    tick();
    chk("midrst", {if8.c_out, if8.S}, 65'd0);
    rstn = 1'b1;
    tick();
    chk("after_midrst", {if8.c_out, if8.S}, 65'h096);

    for (int i = 0; i < 1000; i++) begin
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      c8  = 1'($urandom);
      a1  = 1'($urandom);
      b1  = 1'($urandom);
      c1  = 1'($urandom);
      a64 = {$urandom, $urandom};
      b64 = {$urandom, $urandom};
      c64 = 1'($urandom);
      drive8(a8, b8, c8);
      if1.A = a1; if1.B = b1; if1.c_in = c1;
      if64.A = a64; if64.B = b64; if64.c_in = c64;
      e8  = expected_sum(64'(a8), 64'(b8), c8, 8);
      e1  = expected_sum(64'(a1), 64'(b1), c1, 1);
      e64 = expected_sum(a64, b64, c64, 64);
      tick();
      chk("rnd8", {if8.c_out, if8.S}, e8);
      chk("rnd1", {if1.c_out, if1.S}, e1);
      chk("rnd64", {if64.c_out, if64.S}, e64);
`ifdef N_ADDER_OVF_EN
      chk("rnd8_ovf", if8.ovf, 65'(ovf_rule(a8[7], b8[7], e8[7])));
      chk("rnd1_ovf", if1.ovf, 65'(ovf_rule(a1[0], b1[0], e1[0])));
      chk("rnd64_ovf", if64.ovf,
          65'(ovf_rule(a64[63], b64[63], e64[63])));
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
